// File: rtl/video_stream_rx.sv
// rtl/video_stream_rx.sv - sync video (vsync/valid) to ready/valid stream converter
// Pixels pass through a one-entry stage so eol can be decided from the following cycle's valid.
module video_stream_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int RES_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pre_img_vsync,
  input  logic                  pre_img_hsync,
  input  logic                  pre_img_valid,
  input  logic [DATA_WIDTH-1:0] pre_img_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic [RES_WIDTH-1:0]  frame_xres,
  output logic [RES_WIDTH-1:0]  frame_yres,
  output logic                  res_valid,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, LINE, GAP} state_t;

  state_t state, state_nxt;

  logic unused_hsync;
  assign unused_hsync = pre_img_hsync;

  logic vsync_d;
  logic vs_rise;
  logic accept;
  logic line_end;
  logic trunc;

  logic                  stg_valid;
  logic                  stg_sof;
  logic [DATA_WIDTH-1:0] stg_data;
  logic                  sof_pending;
  logic                  push_eol;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en, drop;

  logic [RES_WIDTH-1:0] x_cnt, y_cnt, first_x;
  logic                 mismatch;

  assign vs_rise  = pre_img_vsync & ~vsync_d;
  assign accept   = pre_img_valid && (state != IDLE) && !vs_rise;
  assign line_end = (state == LINE) && !pre_img_valid && !vs_rise;
  // A frame start arriving mid-line cuts that line short.
  assign trunc    = vs_rise && (pre_img_valid || state == LINE);
  assign push_eol = !pre_img_valid || vs_rise;
  assign mismatch = line_end && (y_cnt != '0) && (x_cnt != first_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (vs_rise) begin
      state_nxt = ARMED;
    end else begin
      case (state)
        ARMED:   if (pre_img_valid)  state_nxt = LINE;
        LINE:    if (!pre_img_valid) state_nxt = GAP;
        GAP:     if (pre_img_valid)  state_nxt = LINE;
        default: state_nxt = state;
      endcase
    end
  end

  // Reset to 1 so a vsync already high at reset release is not taken as a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d     <= 1'b1;
      stg_valid   <= 1'b0;
      stg_sof     <= 1'b0;
      stg_data    <= '0;
      sof_pending <= 1'b0;
    end else begin
      vsync_d   <= pre_img_vsync;
      stg_valid <= accept;
      if (accept) begin
        stg_data <= pre_img_data;
        stg_sof  <= sof_pending;
      end
      if (vs_rise)     sof_pending <= 1'b1;
      else if (accept) sof_pending <= 1'b0;
    end
  end

  assign full  = (count == DEPTH_CNT);
  assign pop   = (count != '0) && m_ready;
  assign wr_en = stg_valid && (!full || pop);
  assign drop  = stg_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {stg_sof, push_eol, stg_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign m_valid = (count != '0);
  assign m_data  = m_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_eol   = m_valid & head[DATA_WIDTH];
  assign m_sof   = m_valid & head[DATA_WIDTH+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      first_x    <= '0;
      frame_xres <= '0;
      frame_yres <= '0;
      res_valid  <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (vs_rise) begin
        if (y_cnt != '0) begin
          frame_xres <= first_x;
          frame_yres <= y_cnt;
          res_valid  <= 1'b1;
        end
        x_cnt   <= '0;
        y_cnt   <= '0;
        first_x <= '0;
      end else if (line_end) begin
        x_cnt <= '0;
        if (y_cnt != '1) y_cnt <= y_cnt + 1'b1;
        if (y_cnt == '0) first_x <= x_cnt;
      end else if (accept && x_cnt != '1) begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // Events in the frame-start cycle survive the clear of the sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (vs_rise) begin
      overflow  <= drop;
      frame_err <= trunc || mismatch;
    end else begin
      overflow  <= overflow | drop;
      frame_err <= frame_err | mismatch;
    end
  end

endmodule

// File: tb/tb_video_stream_rx.sv
// tb/tb_video_stream_rx.sv - randomized self-checking bench for video_stream_rx
// Expected pixel streams are built from frame/line descriptions: sof on frame's first pixel, eol on each line's last.
module tb_video_stream_rx;
  localparam int DW = 8;
  localparam int FD = 16;
  localparam int RW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pre_img_vsync = 1'b0;
  logic          pre_img_hsync = 1'b0;
  logic          pre_img_valid = 1'b0;
  logic [DW-1:0] pre_img_data = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_sof, m_eol;
  logic [RW-1:0] frame_xres, frame_yres;
  logic          res_valid, overflow, frame_err;

  video_stream_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .RES_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pre_img_vsync(pre_img_vsync), .pre_img_hsync(pre_img_hsync),
    .pre_img_valid(pre_img_valid), .pre_img_data(pre_img_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eol(m_eol),
    .frame_xres(frame_xres), .frame_yres(frame_yres),
    .res_valid(res_valid), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int res_pulses = 0;
  int ready_mode = 0;
  logic [DW+1:0] got_q[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) got_q.push_back({m_sof, m_eol, m_data});
    if (res_valid === 1'b1) res_pulses++;
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'b0;
      2: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = ~m_ready;
    endcase
  end

  task automatic cyc(input logic vs, input logic v, input logic [DW-1:0] d);
    pre_img_vsync = vs;
    pre_img_valid = v;
    pre_img_hsync = v;
    pre_img_data  = d;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    pre_img_vsync = 1'b0;
    pre_img_valid = 1'b0;
    pre_img_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic vsync_pulse;
    cyc(0, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    cyc(0, 0, 0); cyc(0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (m_valid === 1'b0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({m_valid, m_sof, m_eol, m_data, res_valid, overflow, frame_err} !== '0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0", {m_valid, m_sof, m_eol, m_data, res_valid, overflow, frame_err});
    end
    do_reset();
    checks++;
    if (frame_xres !== '0 || frame_yres !== '0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_res got=%0d/%0d/%b exp=0/0/0", frame_xres, frame_yres, m_valid);
    end
  endtask

  task automatic test_basic;
    logic [DW+1:0] exp_q[$];
    bit ok;
    do_reset();
    ready_mode = 0;
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 4; i++) begin
        cyc(0, 1, DW'(l*4+i));
        exp_q.push_back({(l == 0 && i == 0), (i == 3), DW'(l*4+i)});
        if (l == 0 && i == 0) begin
          checks++;
          if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_latency_early got=%b exp=0", m_valid); end
        end
        if (l == 0 && i == 1) begin
          checks++;
          if ({m_valid, m_sof, m_data} !== {1'b1, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL basic_latency got=%b/%b/%0d exp=1/1/0", m_valid, m_sof, m_data);
          end
        end
      end
      cyc(0, 0, 0); cyc(0, 0, 0);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_drain timeout got=busy exp=empty"); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_seq[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    checks++;
    if ({res_valid, frame_xres, frame_yres} !== {1'b1, 12'd4, 12'd3}) begin
      failures++;
      $display("FAIL basic_res got=%b/%0d/%0d exp=1/4/3", res_valid, frame_xres, frame_yres);
    end
    cyc(1, 0, 0);
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL basic_res_pulse got=%b exp=0", res_valid); end
    cyc(0, 0, 0);
  endtask

  task automatic test_ready_toggle;
    logic [DW+1:0] exp_q[$];
    bit ok;
    do_reset();
    ready_mode = 3;
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 4; i++) begin
        cyc(0, 1, DW'(l*4+i));
        exp_q.push_back({(l == 0 && i == 0), (i == 3), DW'(l*4+i)});
      end
      cyc(0, 0, 0);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL toggle_drain timeout got=busy exp=empty"); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL toggle_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL toggle_seq[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL toggle_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_random;
    logic [DW+1:0] exp_q[$];
    logic [DW-1:0] d;
    bit ok;
    bit have_prev = 0;
    int px = 0, py = 0, p0, xs, ys;
    do_reset();
    ready_mode = 2;
    for (int f = 0; f <= 6; f++) begin
      p0 = res_pulses;
      vsync_pulse();
      checks++;
      if (have_prev) begin
        if (res_pulses - p0 !== 1 || frame_xres !== RW'(px) || frame_yres !== RW'(py)) begin
          failures++;
          $display("FAIL rand_res[%0d] got=%0d/%0d/%0d exp=1/%0d/%0d", f, res_pulses - p0, frame_xres, frame_yres, px, py);
        end
      end else if (res_pulses - p0 !== 0) begin
        failures++;
        $display("FAIL rand_res_first got=%0d exp=0", res_pulses - p0);
      end
      if (f == 6) break;
      xs = $urandom_range(1, 5);
      ys = $urandom_range(1, 3);
      exp_q.delete();
      got_q.delete();
      for (int l = 0; l < ys; l++) begin
        for (int i = 0; i < xs; i++) begin
          d = DW'($urandom);
          cyc(0, 1, d);
          exp_q.push_back({(l == 0 && i == 0), (i == xs-1), d});
        end
        repeat ($urandom_range(1, 3)) cyc(0, 0, 0);
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rand_drain[%0d] timeout got=busy exp=empty", f); end
      checks++;
      if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", f, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_seq[%0d][%0d] got=%h exp=%h", f, i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (overflow !== 1'b0 || frame_err !== 1'b0) begin
        failures++;
        $display("FAIL rand_flags[%0d] got=%b%b exp=00", f, overflow, frame_err);
      end
      have_prev = 1;
      px = xs;
      py = ys;
    end
  endtask

  task automatic test_overflow;
    logic [DW+1:0] exp_q[$];
    logic [DW-1:0] d;
    bit ok;
    do_reset();
    ready_mode = 1;
    vsync_pulse();
    for (int i = 0; i < 20; i++) begin
      d = DW'($urandom);
      cyc(0, 1, d);
      if (i < FD) exp_q.push_back({(i == 0), 1'b0, d});
    end
    cyc(0, 0, 0); cyc(0, 0, 0);
    checks++;
    if (overflow !== 1'b1 || m_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b/%b exp=1/1", overflow, m_valid);
    end
    vsync_pulse();
    checks++;
    if (overflow !== 1'b0 || frame_xres !== 12'd20 || frame_yres !== 12'd1) begin
      failures++;
      $display("FAIL ovf_clear got=%b/%0d/%0d exp=0/20/1", overflow, frame_xres, frame_yres);
    end
    ready_mode = 0;
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ovf_drain timeout got=busy exp=empty"); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_seq[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_mismatch;
    int lens[3] = '{4, 4, 5};
    logic [DW+1:0] exp_q[$];
    logic [DW-1:0] d;
    bit ok;
    do_reset();
    ready_mode = 0;
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < lens[l]; i++) begin
        d = DW'($urandom);
        cyc(0, 1, d);
        exp_q.push_back({(l == 0 && i == 0), (i == lens[l]-1), d});
      end
      cyc(0, 0, 0); cyc(0, 0, 0);
      checks++;
      if (frame_err !== (l == 2)) begin failures++; $display("FAIL mism_err_line%0d got=%b exp=%b", l, frame_err, (l == 2)); end
    end
    wait_drain(ok);
    checks++;
    if (got_q.size() !== exp_q.size() || !ok) begin failures++; $display("FAIL mism_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL mism_seq[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    vsync_pulse();
    checks++;
    if (frame_xres !== 12'd4 || frame_yres !== 12'd3 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL mism_res got=%0d/%0d/%b exp=4/3/0", frame_xres, frame_yres, frame_err);
    end
  endtask

  task automatic test_vsync_in_line;
    logic [DW+1:0] exp_q[$];
    logic [DW-1:0] d;
    bit ok;
    int p0;
    do_reset();
    ready_mode = 0;
    vsync_pulse();
    p0 = res_pulses;
    for (int i = 0; i < 3; i++) begin
      d = DW'($urandom);
      cyc(0, 1, d);
      exp_q.push_back({(i == 0), (i == 2), d});
    end
    cyc(1, 1, 8'hEE);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    checks++;
    if (frame_err !== 1'b1 || res_pulses !== p0) begin
      failures++;
      $display("FAIL vsl_err got=%b/%0d exp=1/0", frame_err, res_pulses - p0);
    end
    for (int i = 0; i < 2; i++) begin
      d = DW'($urandom);
      cyc(0, 1, d);
      exp_q.push_back({(i == 0), (i == 1), d});
    end
    cyc(0, 0, 0); cyc(0, 0, 0);
    wait_drain(ok);
    checks++;
    if (got_q.size() !== exp_q.size() || !ok) begin failures++; $display("FAIL vsl_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL vsl_seq[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    vsync_pulse();
    checks++;
    if (frame_err !== 1'b0 || frame_xres !== 12'd2 || frame_yres !== 12'd1) begin
      failures++;
      $display("FAIL vsl_res got=%b/%0d/%0d exp=0/2/1", frame_err, frame_xres, frame_yres);
    end
  endtask

  task automatic test_reset_mid;
    logic [DW+1:0] exp_q[$];
    logic [DW-1:0] d;
    bit ok;
    do_reset();
    ready_mode = 1;
    vsync_pulse();
    cyc(0, 1, 8'h11);
    cyc(0, 1, 8'h22);
    checks++;
    if (m_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%b exp=1", m_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0) begin failures++; $display("FAIL rmid_async got=%b/%h exp=0/00", m_valid, m_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    got_q.delete();
    ready_mode = 0;
    cyc(0, 1, 8'h33); cyc(0, 1, 8'h44); cyc(0, 1, 8'h55);
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    checks++;
    if (got_q.size() !== 0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_blocked got=%0d/%b exp=0/0", got_q.size(), m_valid);
    end
    vsync_pulse();
    for (int i = 0; i < 3; i++) begin
      d = DW'($urandom);
      cyc(0, 1, d);
      exp_q.push_back({(i == 0), (i == 2), d});
    end
    wait_drain(ok);
    checks++;
    if (got_q.size() !== exp_q.size() || !ok) begin failures++; $display("FAIL rmid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rmid_seq[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_random();
    test_overflow();
    test_mismatch();
    test_vsync_in_line();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
